// File: rtl/timer_bus_if.sv
// timer_bus_if: Ibex-style req/gnt/rvalid data bus between the core and a responder.
interface timer_bus_if;
    logic        req_i;
    logic        gnt_o;
    logic        rvalid_o;
    logic        err_o;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    modport master(output req_i, we_i, be_i, addr_i, wdata_i, input gnt_o, rvalid_o, err_o, rdata_o);
    modport slave(input req_i, we_i, be_i, addr_i, wdata_i, output gnt_o, rvalid_o, err_o, rdata_o);
endinterface

// File: rtl/timer_bus_resp.sv
// timer_bus_resp: memory-mapped machine timer (mtime/mtimecmp/CTRL) on the Ibex data bus.
module timer_bus_resp #(
    parameter logic [31:0] BaseAddr   = 32'h0002_0000,
    parameter int unsigned WaitCycles = 0
) (
    input  logic clk_i,
    input  logic rst_i,
    timer_bus_if.slave bus,
    output logic irq_timer_o
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t      state;
    logic [3:0]  wcnt;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        en;
    logic [7:0]  prescale;
    logic [7:0]  pcnt;
    logic [31:0] shadow_hi;
    logic        grant;
    logic        hit;
    logic        wr;
    logic        tick;
    logic [2:0]  off;
    logic [31:0] wmask;
    logic [31:0] rd;
    logic [63:0] mtime_inc;
    logic [63:0] mtime_n;
    logic [63:0] cmp_n;
    logic        unused_addr;
    assign unused_addr = ^bus.addr_i[1:0];
    assign bus.gnt_o = grant;
    always_comb begin
        grant = bus.req_i && ((state == IDLE && WaitCycles == 0) ||
                              (state == WAIT && wcnt == 4'(WaitCycles)));
        off = bus.addr_i[4:2];
        hit = bus.addr_i[31:5] == BaseAddr[31:5] && off <= 3'd4;
        wr = grant && bus.we_i && hit;
        wmask = {{8{bus.be_i[3]}}, {8{bus.be_i[2]}}, {8{bus.be_i[1]}}, {8{bus.be_i[0]}}};
        tick = en && pcnt == prescale;
        mtime_inc = mtime + {63'b0, tick};
        // Written bytes override, unwritten bytes keep this cycle's incremented value
        mtime_n[31:0] = (wr && off == 3'd0) ? ((bus.wdata_i & wmask) | (mtime_inc[31:0] & ~wmask)) : mtime_inc[31:0];
        mtime_n[63:32] = (wr && off == 3'd1) ? ((bus.wdata_i & wmask) | (mtime_inc[63:32] & ~wmask)) : mtime_inc[63:32];
        cmp_n[31:0] = (wr && off == 3'd2) ? ((bus.wdata_i & wmask) | (mtimecmp[31:0] & ~wmask)) : mtimecmp[31:0];
        cmp_n[63:32] = (wr && off == 3'd3) ? ((bus.wdata_i & wmask) | (mtimecmp[63:32] & ~wmask)) : mtimecmp[63:32];
        rd = off == 3'd0 ? mtime[31:0] :
             off == 3'd1 ? shadow_hi :
             off == 3'd2 ? mtimecmp[31:0] :
             off == 3'd3 ? mtimecmp[63:32] : {16'b0, prescale, 7'b0, en};
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            wcnt         <= 4'd1;
            bus.rvalid_o <= 1'b0;
            bus.err_o    <= 1'b0;
            bus.rdata_o  <= 32'b0;
            irq_timer_o  <= 1'b0;
            mtime        <= 64'b0;
            mtimecmp     <= '1;
            en           <= 1'b0;
            prescale     <= 8'b0;
            pcnt         <= 8'b0;
            shadow_hi    <= 32'b0;
        end else begin
            state        <= grant ? RESP : (state != RESP && bus.req_i) ? WAIT : IDLE;
            wcnt         <= state == WAIT ? wcnt + 4'd1 : 4'd1;
            bus.rvalid_o <= grant;
            if (grant) begin
                bus.rdata_o <= (hit && !bus.we_i) ? rd : 32'b0;
                bus.err_o   <= !hit;
            end
            if (en)
                pcnt <= tick ? 8'b0 : pcnt + 8'd1;
            mtime       <= mtime_n;
            mtimecmp    <= cmp_n;
            irq_timer_o <= mtime_n >= cmp_n;
            // Reading LO snapshots HI so a LO/HI pair is coherent
            if (grant && hit && !bus.we_i && off == 3'd0)
                shadow_hi <= mtime[63:32];
            if (wr && off == 3'd4 && bus.be_i[0])
                en <= bus.wdata_i[0];
            if (wr && off == 3'd4 && bus.be_i[1])
                prescale <= bus.wdata_i[15:8];
        end
    end
endmodule
